// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port dmem between two requesters with tagged read return (DMEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority)
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);
    logic                  last_grant;
    logic                  win1;
    logic                  accept;
    logic                  sel_we;
    logic [READ_LATENCY:0] pv;
    logic [READ_LATENCY:0] pid;

    // pick the winner from current requests and the previous grant
    always_comb begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        win1 = req1 && (!req0 || !last_grant);
`else
        win1 = req1 && !req0;
`endif
        gnt1   = !reset && win1;
        gnt0   = !reset && req0 && !win1;
        accept = gnt0 || gnt1;
        sel_we = gnt1 ? we1 : we0;
    end

    // register the winning access onto the dmem pins; idle cycles only drop the write enable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            mem_wren <= accept && sel_we;
            if (accept) begin
                mem_address <= gnt1 ? addr1 : addr0;
                mem_data    <= gnt1 ? wdata1 : wdata0;
                last_grant  <= gnt1;
            end
        end
    end

    // stage 0 lines up with the pins; the top stage lines up with mem_q being valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pv  <= '0;
            pid <= '0;
        end else begin
            pv  <= {pv[READ_LATENCY-1:0], accept && !sel_we};
            pid <= {pid[READ_LATENCY-1:0], gnt1};
        end
    end

    assign rvalid0 = pv[READ_LATENCY] && !pid[READ_LATENCY];
    assign rvalid1 = pv[READ_LATENCY] && pid[READ_LATENCY];
    assign rdata0  = mem_q;
    assign rdata1  = mem_q;
endmodule
